// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared constants for the RV32M iterative multiply/divide unit:
//   - 2-bit FSM state encodings (legacy-compatible localparams)
//   - operation select and operand signedness encodings
//   - word widths used by the datapath
// -----------------------------------------------------------------------------
package muldiv_pkg;

   localparam int XLEN    = 32;
   localparam int DXLEN   = 64;

   // FSM states
   localparam logic [1:0] MD_IDLE = 2'd0;
   localparam logic [1:0] MD_CALC = 2'd1;
   localparam logic [1:0] MD_FIX  = 2'd2;
   localparam logic [1:0] MD_DONE = 2'd3;

   // Operation select on mul_or_div_i
   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   // Operand signedness flags
   localparam logic OPND_SIGNED   = 1'b0;
   localparam logic OPND_UNSIGNED = 1'b1;

   localparam logic [XLEN-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/muldiv.sv
// -----------------------------------------------------------------------------
// muldiv
// Iterative multiply/divide responder for the EX stage (RV32M).
// EX holds start_i high with operands; 34 cycles after the accept cycle the
// unit pulses done_o for one cycle with a 64-bit result:
//   multiply -> {hi, lo} product, divide -> {quotient, remainder}.
// Ports:
//   clk                       system clock
//   rst                       synchronous reset, active-low
//   start_i                   level request, held until done_o
//   mul_or_div_i              0 = multiply, 1 = divide
//   dividend_i                multiplicand / dividend (reg1)
//   divisor_i                 multiplier / divisor (reg2)
//   reg1_signed0_unsigned1_i  signedness of dividend_i (0 signed, 1 unsigned)
//   reg2_signed0_unsigned1_i  signedness of divisor_i  (0 signed, 1 unsigned)
//   result_o                  registered result, valid while done_o = 1
//   done_o                    one-cycle completion pulse
//   busy_o                    high whenever the unit is not idle
// -----------------------------------------------------------------------------
module muldiv
   import muldiv_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              mul_or_div_i,
   input  logic [XLEN-1:0]   dividend_i,
   input  logic [XLEN-1:0]   divisor_i,
   input  logic              reg1_signed0_unsigned1_i,
   input  logic              reg2_signed0_unsigned1_i,
   output logic [DXLEN-1:0]  result_o,
   output logic              done_o,
   output logic              busy_o
);

   function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] v);
      return ~v + 32'd1;
   endfunction

   function automatic logic [DXLEN-1:0] neg64(input logic [DXLEN-1:0] v);
      return ~v + 64'd1;
   endfunction

   logic [1:0]       state, state_nxt;
   logic [4:0]       cnt;
   logic             op_div;
   logic             neg_hi;     // product sign (MUL) or quotient sign (DIV)
   logic             neg_r;
   logic             div_zero;
   logic             div_ovf;
   logic [XLEN-1:0]  orig_a;     // raw dividend, returned as remainder on /0
   logic [DXLEN-1:0] mcand;      // |a| shifted left one place per step
   logic [DXLEN-1:0] acc;
   logic [XLEN-1:0]  op_b;       // multiplier (shifts right) or divisor (static)
   logic [XLEN-1:0]  dvd_q;      // dividend bits shift out, quotient bits shift in
   logic [XLEN-1:0]  rem;

   logic             neg_a, neg_b;
   logic [XLEN-1:0]  abs_a, abs_b;
   logic [XLEN:0]    rem_sh;
   logic             q_bit;

   assign neg_a = (reg1_signed0_unsigned1_i == OPND_SIGNED) && dividend_i[XLEN-1];
   assign neg_b = (reg2_signed0_unsigned1_i == OPND_SIGNED) && divisor_i[XLEN-1];
   assign abs_a = neg_a ? neg32(dividend_i) : dividend_i;
   assign abs_b = neg_b ? neg32(divisor_i)  : divisor_i;

   // Restoring step: bring down the next dividend bit, subtract if it fits.
   assign rem_sh = {rem, dvd_q[XLEN-1]};
   assign q_bit  = (rem_sh >= {1'b0, op_b});

   assign done_o = (state == MD_DONE);
   assign busy_o = (state != MD_IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         MD_IDLE: if (start_i) state_nxt = MD_CALC;
         MD_CALC: begin
            if (!start_i)        state_nxt = MD_IDLE;
            else if (cnt == 5'd31) state_nxt = MD_FIX;
         end
         MD_FIX:  state_nxt = start_i ? MD_DONE : MD_IDLE;
         MD_DONE: state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= MD_IDLE;
         result_o <= '0;
         cnt      <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            // accept: capture magnitudes, result signs and special cases
            MD_IDLE: begin
               if (start_i) begin
                  op_div   <= (mul_or_div_i == OP_DIV);
                  neg_hi   <= neg_a ^ neg_b;
                  neg_r    <= neg_a;
                  div_zero <= (divisor_i == ZERO_WORD);
                  div_ovf  <= (reg1_signed0_unsigned1_i == OPND_SIGNED) &&
                              (reg2_signed0_unsigned1_i == OPND_SIGNED) &&
                              (dividend_i == 32'h8000_0000) &&
                              (divisor_i  == 32'hFFFF_FFFF);
                  orig_a   <= dividend_i;
                  mcand    <= {ZERO_WORD, abs_a};
                  acc      <= '0;
                  op_b     <= abs_b;
                  dvd_q    <= abs_a;
                  rem      <= '0;
                  cnt      <= '0;
                  result_o <= '0;
               end
            end
            // iterate: one multiplier bit (LSB first) or one quotient bit (MSB first)
            MD_CALC: begin
               if (start_i) begin
                  cnt <= cnt + 5'd1;
                  if (op_div) begin
                     rem   <= q_bit ? (rem_sh[XLEN-1:0] - op_b) : rem_sh[XLEN-1:0];
                     dvd_q <= {dvd_q[XLEN-2:0], q_bit};
                  end else begin
                     acc   <= acc + (op_b[0] ? mcand : 64'd0);
                     mcand <= mcand << 1;
                     op_b  <= op_b >> 1;
                  end
               end
            end
            // sign fix-up and RISC-V special cases
            MD_FIX: begin
               if (start_i) begin
                  if (!op_div)
                     result_o <= neg_hi ? neg64(acc) : acc;
                  else if (div_zero)
                     result_o <= {32'hFFFF_FFFF, orig_a};
                  else if (div_ovf)
                     result_o <= {32'h8000_0000, ZERO_WORD};
                  else
                     result_o <= {neg_hi ? neg32(dvd_q) : dvd_q,
                                  neg_r  ? neg32(rem)   : rem};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv.sv
module tb_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic        mul_or_div_i = 1'b0;
   logic [31:0] dividend_i = '0;
   logic [31:0] divisor_i = '0;
   logic        s1 = 1'b0;
   logic        s2 = 1'b0;
   logic [63:0] result_o;
   logic        done_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   muldiv dut (
      .clk                      (clk),
      .rst                      (rst),
      .start_i                  (start_i),
      .mul_or_div_i             (mul_or_div_i),
      .dividend_i               (dividend_i),
      .divisor_i                (divisor_i),
      .reg1_signed0_unsigned1_i (s1),
      .reg2_signed0_unsigned1_i (s2),
      .result_o                 (result_o),
      .done_o                   (done_o),
      .busy_o                   (busy_o)
   );

   always #5 clk = ~clk;

   // Reference: extend each operand to 64 bits per its flag and use plain
   // 64-bit arithmetic (division truncates toward zero, as RISC-V requires).
   function automatic logic [63:0] ref_model(input logic is_div, input logic [31:0] a,
                                             input logic [31:0] b, input logic ua,
                                             input logic ub);
      longint sa, sb, q, r;
      logic [63:0] p, qv, rv;
      sa = ua ? longint'({32'd0, a}) : longint'({{32{a[31]}}, a});
      sb = ub ? longint'({32'd0, b}) : longint'({{32{b[31]}}, b});
      if (!is_div) begin
         p = sa * sb;
         return p;
      end
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      q = sa / sb;
      r = sa % sb;
      qv = q;
      rv = r;
      return {qv[31:0], rv[31:0]};
   endfunction

   // Drives one request from an idle unit; returns latency in cycles from the
   // accept cycle, the result at done, and done_o one cycle later.
   task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                         input logic ua, input logic ub, input bit scramble,
                         output logic [63:0] res, output int lat, output logic done_next);
      @(negedge clk);
      mul_or_div_i = is_div; dividend_i = a; divisor_i = b; s1 = ua; s2 = ub;
      start_i = 1'b1;
      lat = 0;
      while (lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (scramble) begin
            dividend_i = $urandom; divisor_i = $urandom;
            s1 = 1'($urandom); s2 = 1'($urandom); mul_or_div_i = 1'($urandom);
         end
         if (done_o) break;
      end
      res = result_o;
      start_i = 1'b0;
      @(posedge clk); #1;
      done_next = done_o;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", result_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
      start_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic        d_div [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [31:0] d_a   [8] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFF9, 32'd100, 32'h1234, 32'h8000_0000};
      logic [31:0] d_b   [8] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
      logic        d_ua  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic        d_ub  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [63:0] d_exp [8] = '{64'h0000_0000_0000_002A, 64'h0000_0000_0000_0001,
                                 64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE,
                                 64'hFFFF_FFFD_FFFF_FFFF, 64'h0000_000E_0000_0002,
                                 64'hFFFF_FFFF_0000_1234, 64'h8000_0000_0000_0000};
      logic [63:0] res;
      int          lat;
      logic        dn;
      for (int i = 0; i < 8; i++) begin
         run_op(d_div[i], d_a[i], d_b[i], d_ua[i], d_ub[i], 1'b0, res, lat, dn);
         checks++; if (lat !== 34) begin errors++; $display("FAIL dir%0d_latency got %0d want 34", i, lat); end
         checks++; if (res !== d_exp[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, res, d_exp[i]); end
         checks++; if (dn !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b want 0", i, dn); end
         repeat (2) @(posedge clk);
         #1;
         checks++; if (result_o !== d_exp[i]) begin errors++; $display("FAIL dir%0d_hold got %h want %h", i, result_o, d_exp[i]); end
      end
   endtask

   task automatic test_random();
      logic [63:0] res, exp;
      int          lat;
      logic        dn, is_div, ua, ub;
      logic [31:0] a, b;
      for (int i = 0; i < 48; i++) begin
         is_div = 1'($urandom);
         ua = 1'($urandom);
         ub = 1'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = b & 32'h0000_00FF;
            3: a = a & 32'h0000_FFFF;
            default: ;
         endcase
         exp = ref_model(is_div, a, b, ua, ub);
         run_op(is_div, a, b, ua, ub, 1'b1, res, lat, dn);
         checks++; if (lat !== 34) begin errors++; $display("FAIL rnd%0d_latency got %0d want 34", i, lat); end
         checks++;
         if (res !== exp) begin
            errors++;
            $display("FAIL rnd%0d_result div=%b a=%h b=%h ua=%b ub=%b got %h want %h", i, is_div, a, b, ua, ub, res, exp);
         end
      end
   endtask

   // Abort by dropping start in CALC (cycle 10) and in FIX (cycle 33), then
   // restart immediately from the following idle cycle.
   task automatic test_abort_restart();
      int          drop_at [2] = '{10, 33};
      logic        seen;
      logic [63:0] res, exp;
      int          lat;
      logic        dn;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         mul_or_div_i = 1'b1; dividend_i = 32'd1000; divisor_i = 32'd3; s1 = 1'b0; s2 = 1'b0;
         start_i = 1'b1;
         repeat (drop_at[k]) @(posedge clk);
         #1;
         checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL abort%0d_busy_before got %b want 1", k, busy_o); end
         start_i = 1'b0;
         @(posedge clk); #1;
         checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort%0d_idle got busy %b want 0", k, busy_o); end
         seen = done_o;
         for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            seen = seen | done_o;
         end
         checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort%0d_no_done got %b want 0", k, seen); end
         checks++; if (result_o !== 64'd0) begin errors++; $display("FAIL abort%0d_result got %h want 0", k, result_o); end
      end
      exp = ref_model(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
      run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 1'b0, res, lat, dn);
      checks++; if (lat !== 34) begin errors++; $display("FAIL restart_latency got %0d want 34", lat); end
      checks++; if (res !== exp) begin errors++; $display("FAIL restart_result got %h want %h", res, exp); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] res, exp;
      int          lat;
      logic        dn;
      exp = ref_model(1'b0, 32'd123, 32'd456, 1'b1, 1'b1);
      run_op(1'b0, 32'd123, 32'd456, 1'b1, 1'b1, 1'b0, res, lat, dn);
      checks++; if (result_o !== exp) begin errors++; $display("FAIL rstidle_pre got %h want %h", result_o, exp); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (result_o !== 64'd0) begin errors++; $display("FAIL rstidle_result got %h want 0", result_o); end
      rst = 1'b1;
      @(negedge clk);
      mul_or_div_i = 1'b1; dividend_i = 32'd99; divisor_i = 32'd5; s1 = 1'b1; s2 = 1'b1;
      start_i = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done_o); end
      checks++; if (result_o !== 64'd0) begin errors++; $display("FAIL rstmid_result got %h want 0", result_o); end
      start_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      exp = ref_model(1'b1, 32'hFFFF_FF00, 32'd7, 1'b0, 1'b0);
      run_op(1'b1, 32'hFFFF_FF00, 32'd7, 1'b0, 1'b0, 1'b0, res, lat, dn);
      checks++; if (res !== exp || lat !== 34) begin errors++; $display("FAIL rstmid_recover got %h lat %0d want %h lat 34", res, lat, exp); end
   endtask

   // start held high through DONE: the second op must not be taken in DONE,
   // only in the idle cycle after it, finishing 34 cycles after that accept.
   task automatic test_back_to_back();
      logic [63:0] exp1, exp2;
      int          lat;
      exp1 = ref_model(1'b0, 32'hDEAD_BEEF, 32'h0000_1001, 1'b1, 1'b1);
      exp2 = ref_model(1'b1, 32'hDEAD_BEEF, 32'h0000_1001, 1'b0, 1'b0);
      @(negedge clk);
      mul_or_div_i = 1'b0; dividend_i = 32'hDEAD_BEEF; divisor_i = 32'h0000_1001; s1 = 1'b1; s2 = 1'b1;
      start_i = 1'b1;
      lat = 0;
      while (lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (done_o) break;
      end
      checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_first_latency got %0d want 34", lat); end
      checks++; if (result_o !== exp1) begin errors++; $display("FAIL b2b_first_result got %h want %h", result_o, exp1); end
      mul_or_div_i = 1'b1; s1 = 1'b0; s2 = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got busy %b done %b want 0 0", busy_o, done_o); end
      lat = 0;
      while (lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (done_o) break;
      end
      checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_second_latency got %0d want 34", lat); end
      checks++; if (result_o !== exp2) begin errors++; $display("FAIL b2b_second_result got %h want %h", result_o, exp2); end
      start_i = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_abort_restart();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
